spi_slave_receiver: RTL and testbench
=====================================

Name: spi_slave_receiver

Overview:
- Peripheral-side end of the serial link driven by our SPI shift-register transmitter.
- Oversamples SCLK/CS_N/MOSI/DC on the system clock and deserialises MSB-first words.
- Presents each word with its D/C flag on a valid/ready interface, and optionally returns a word on MISO.
- Used as an SSD1306-style display model in simulation and as a generic SPI target (SPI mode 0) on-chip.

Parameters:
- WIDTH, 8, bits per word.
- SYNC_STAGES, 2, synchroniser flops on each asynchronous input (minimum 2).

Ports:
- clk_in  input  1  system clock; must run at least 4x SCLK frequency.
- reset_in  input  1  asynchronous, active-high reset.
- sclk_in  input  1  serial clock from master, idle low.
- cs_n_in  input  1  chip select, active low.
- mosi_in  input  1  serial data from master, MSB first.
- dc_in  input  1  data/command flag; 1 = data, 0 = command.
- miso_out  output  1  serial data to master.
- rx_data_out  output  WIDTH  received word.
- rx_dc_out  output  1  dc_in value sampled with the last bit of the word.
- rx_valid_out  output  1  rx_data_out/rx_dc_out are valid.
- rx_ready_in  input  1  consumer accepts the word.
- rx_overrun_out  output  1  one-cycle pulse: word dropped because the previous word was not yet accepted.
- frame_error_out  output  1  one-cycle pulse: CS_N deasserted mid-word.
- tx_data_in  input  WIDTH  next word to return on MISO.
- tx_load_in  input  1  write tx_data_in into the TX holding register.

Behaviour:
- Reset (asynchronous assert, released on clk_in):
  - All outputs 0.
  - Synchroniser reset values: sclk 0, cs_n 1, mosi 0, dc 0.
  - Bit counter, RX shift register, TX holding register and TX shift register all 0.
- Synchronisation: sclk/cs_n/mosi/dc each pass through SYNC_STAGES flops. One further flop on synced sclk and cs_n provides edge detection. All decisions use synced values only.
- Active frame: synced cs_n == 0. While cs_n == 1:
  - Bit counter held at 0.
  - SCLK edges ignored.
  - miso_out = 0.
- Frame start (synced cs_n falling edge):
  - TX shift register loads the TX holding register.
  - Bit counter set to 0.
- SCLK rising edge in frame:
  - RX shift register <= {rx_shift[WIDTH-2:0], mosi_s}.
  - Counter increments.
  - On the WIDTH-th bit: word complete, counter wraps to 0, dc_s captured.
- SCLK falling edge in frame:
  - TX shift register shifts left, filling with 0.
  - If the falling edge follows a word completion, TX shift register reloads from the TX holding register instead.
- miso_out = TX shift register MSB while in frame.
- Word completion, evaluated at the clk_in edge on which the last bit is shifted in:
  - rx_valid_out == 0, or rx_ready_in == 1 in that same cycle: rx_data_out/rx_dc_out load the new word; rx_valid_out = 1 in the next cycle.
  - Otherwise (rx_valid_out == 1 and rx_ready_in == 0): new word discarded, held word unchanged, rx_overrun_out pulses for one cycle.
- RX handshake:
  - Transfer occurs on any cycle with rx_valid_out && rx_ready_in.
  - rx_valid_out clears after a transfer unless a word completes in the same cycle.
  - rx_data_out and rx_dc_out are stable while rx_valid_out == 1.
- Latency: last SCLK rising edge at the pin to rx_valid_out high is exactly SYNC_STAGES+2 clk_in cycles, constant for every word.
- Synced cs_n rising edge with counter != 0:
  - frame_error_out pulses for one cycle.
  - Partial word discarded, counter set to 0.
  - A pending rx_valid_out word is unaffected.
- TX holding register:
  - Written on any cycle with tx_load_in, including mid-frame.
  - Retains its value until rewritten.
  - Each word boundary and each frame start reuses the current holding value.
- Simultaneous events:
  - cs_n rise in the same cycle as an SCLK rising edge: the edge is ignored.
  - Word completion and RX transfer in the same cycle: the new word replaces the old one with no bubble.
- Reset mid-word: partial word and pending output cleared immediately; no pulses are generated.

Test Plan:
- Reset, cs_n=0, send 0xA5 with dc=1, SCLK = clk/4, rx_ready=1 -> rx_data_out=0xA5, rx_dc_out=1, rx_valid_out high exactly 4 cycles after the last SCLK rise; frame_error_out and rx_overrun_out stay 0.
- Back-to-back 0xAE (dc=0), 0x3C (dc=1), 0xFF (dc=1) in one frame, rx_ready=1 -> three valid pulses in order with matching dc flags; counter wraps cleanly.
- rx_ready=0, send 0x11 then 0x22 -> rx_data_out holds 0x11, one rx_overrun_out pulse; raise rx_ready -> 0x11 accepted, rx_valid_out drops, 0x22 never appears.
- tx_load 0xC3 before frame, master sends 0x00, 0x00 -> MISO yields 0xC3 then 0xC3; tx_load 0x5A mid-first-word -> second word on MISO is 0x5A.
- Deassert cs_n after 5 bits -> frame_error_out pulses once, no rx_valid_out; next full frame of 0x81 received correctly.
- Assert reset_in during bit 3 with a word pending -> rx_valid_out=0 immediately, all outputs 0; a subsequent frame of 0x42 is received correctly.

Source files
------------

// File: rtl/spi_slave_receiver.sv
// SPI mode-0 target: oversamples SCLK/CS_N/MOSI/DC, deserialises MSB-first words, returns TX words on MISO.
// Word to rx_valid_out is SYNC_STAGES+2 clk_in cycles; a word arriving while one is still held is dropped with an overrun pulse.
module spi_slave_receiver #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             sclk_in,
    input  logic             cs_n_in,
    input  logic             mosi_in,
    input  logic             dc_in,
    output logic             miso_out,
    output logic [WIDTH-1:0] rx_data_out,
    output logic             rx_dc_out,
    output logic             rx_valid_out,
    input  logic             rx_ready_in,
    output logic             rx_overrun_out,
    output logic             frame_error_out,
    input  logic [WIDTH-1:0] tx_data_in,
    input  logic             tx_load_in
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [SYNC_STAGES-1:0] sclk_sync, cs_n_sync, mosi_sync, dc_sync;
    logic sclk_s, cs_n_s, mosi_s, dc_s;
    logic sclk_d, cs_n_d;

    // Registered edge/level stage: every decision below sees one aligned snapshot.
    logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_q, mosi_q, dc_q;

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_hold;
    logic [WIDTH-1:0] tx_shift;
    logic             reload_pending;

    logic             in_frame;
    logic             word_done;
    logic [WIDTH-1:0] new_word;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign dc_s   = dc_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sclk_sync <= '0;
            cs_n_sync <= '1;
            mosi_sync <= '0;
            dc_sync   <= '0;
            sclk_d    <= 1'b0;
            cs_n_d    <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            dc_q      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], cs_n_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc_in};
            sclk_d    <= sclk_s;
            cs_n_d    <= cs_n_s;
            sclk_rise <= sclk_s & ~sclk_d;
            sclk_fall <= ~sclk_s & sclk_d;
            cs_fall   <= ~cs_n_s & cs_n_d;
            cs_rise   <= cs_n_s & ~cs_n_d;
            cs_n_q    <= cs_n_s;
            mosi_q    <= mosi_s;
            dc_q      <= dc_s;
        end
    end

    // A cs_n rise coinciding with an SCLK rise already has cs_n_q high, so the edge is ignored.
    assign in_frame  = ~cs_n_q;
    assign word_done = in_frame && !cs_fall && sclk_rise && (bit_cnt == CW'(WIDTH - 1));
    assign new_word  = {rx_shift[WIDTH-2:0], mosi_q};

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (!in_frame || cs_fall) begin
            bit_cnt <= '0;
        end else if (sclk_rise) begin
            rx_shift <= new_word;
            bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rx_data_out     <= '0;
            rx_dc_out       <= 1'b0;
            rx_valid_out    <= 1'b0;
            rx_overrun_out  <= 1'b0;
            frame_error_out <= 1'b0;
        end else begin
            rx_overrun_out  <= 1'b0;
            frame_error_out <= cs_rise && (bit_cnt != '0);
            if (word_done) begin
                if (!rx_valid_out || rx_ready_in) begin
                    rx_data_out  <= new_word;
                    rx_dc_out    <= dc_q;
                    rx_valid_out <= 1'b1;
                end else begin
                    rx_overrun_out <= 1'b1;
                end
            end else if (rx_valid_out && rx_ready_in) begin
                rx_valid_out <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            tx_hold <= '0;
        end else if (tx_load_in) begin
            tx_hold <= tx_data_in;
        end
    end

    // The falling edge after a completed word starts the next TX word instead of shifting.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            tx_shift       <= '0;
            reload_pending <= 1'b0;
        end else if (cs_fall) begin
            tx_shift       <= tx_hold;
            reload_pending <= 1'b0;
        end else if (in_frame) begin
            if (word_done) begin
                reload_pending <= 1'b1;
            end else if (sclk_fall) begin
                tx_shift       <= reload_pending ? tx_hold : {tx_shift[WIDTH-2:0], 1'b0};
                reload_pending <= 1'b0;
            end
        end else begin
            reload_pending <= 1'b0;
        end
    end

    assign miso_out = in_frame ? tx_shift[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Bench for spi_slave_receiver: directed scenarios plus random frames against a queue-based arrival model.
module tb_spi_slave_receiver;
    localparam int LAT = 4;

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b1;
    logic       sclk_in = 1'b0;
    logic       cs_n_in = 1'b1;
    logic       mosi_in = 1'b0;
    logic       dc_in = 1'b0;
    logic       rx_ready_in = 1'b0;
    logic       tx_load_in = 1'b0;
    logic [7:0] tx_data_in = 8'h00;
    logic       miso_out;
    logic [7:0] rx_data_out;
    logic       rx_dc_out;
    logic       rx_valid_out;
    logic       rx_overrun_out;
    logic       frame_error_out;

    spi_slave_receiver #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
        .mosi_in(mosi_in), .dc_in(dc_in), .miso_out(miso_out), .rx_data_out(rx_data_out),
        .rx_dc_out(rx_dc_out), .rx_valid_out(rx_valid_out), .rx_ready_in(rx_ready_in),
        .rx_overrun_out(rx_overrun_out), .frame_error_out(frame_error_out),
        .tx_data_in(tx_data_in), .tx_load_in(tx_load_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         at;
        logic [7:0] d;
        logic       dc;
        bit         ferr;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    bit         chk_on = 0;
    bit         rdy_mode = 0;
    logic       m_valid = 0, m_dc = 0, m_ovr = 0, m_ferr = 0;
    logic [7:0] m_data = 0;
    int         ovr_seen = 0, ferr_seen = 0, valid_rise_cyc = 0, last_rise = 0;
    logic       prev_valid = 0;
    logic       miso_log [0:65535];
    logic [7:0] tx_model = 8'h00;
    logic [7:0] fr_d[$];
    logic       fr_dcq[$];
    int         partial_bits = 0;
    int         half = 2;
    int         mid_load_word = -1;
    logic [7:0] mid_load_val = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Output model: words land LAT cycles after their last pin-level SCLK rise.
    always @(posedge clk_in) begin : model
        ev_t        e;
        bit         arrived;
        logic [7:0] nd;
        logic       ndc;
        cyc = cyc + 1;
        arrived = 0;
        nd = 8'h00;
        ndc = 1'b0;
        if (reset_in) begin
            m_valid = 0; m_data = 0; m_dc = 0; m_ovr = 0; m_ferr = 0;
            evq.delete();
        end else begin
            m_ovr = 0;
            m_ferr = 0;
            while (evq.size() > 0 && evq[0].at <= cyc) begin
                e = evq.pop_front();
                if (e.ferr) m_ferr = 1;
                else begin
                    arrived = 1; nd = e.d; ndc = e.dc;
                end
            end
            if (arrived) begin
                if (!m_valid || rx_ready_in) begin
                    m_valid = 1; m_data = nd; m_dc = ndc;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && rx_ready_in) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk_in) begin
        miso_log[cyc % 65536] = miso_out;
        if (chk_on && !reset_in) begin
            check("rx_valid", {31'd0, rx_valid_out}, {31'd0, m_valid});
            check("rx_data", {24'd0, rx_data_out}, {24'd0, m_data});
            check("rx_dc", {31'd0, rx_dc_out}, {31'd0, m_dc});
            check("overrun", {31'd0, rx_overrun_out}, {31'd0, m_ovr});
            check("frame_error", {31'd0, frame_error_out}, {31'd0, m_ferr});
            ovr_seen  += int'(rx_overrun_out);
            ferr_seen += int'(frame_error_out);
            if (rx_valid_out && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = rx_valid_out;
        end
    end

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (rdy_mode) rx_ready_in = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
        tx_load_in = 1'b0;
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data_in = v;
        tx_load_in = 1'b1;
        tx_model = v;
        tick();
    endtask

    task automatic send_bit(input logic b);
        mosi_in = b;
        repeat (half) tick();
        sclk_in = 1'b1;
        last_rise = cyc;
        repeat (half) tick();
        sclk_in = 1'b0;
    endtask

    task automatic do_frame();
        int         rc[$];
        logic [7:0] ex[$];
        logic [7:0] got;
        cs_n_in = 1'b0;
        tick();
        tick();
        for (int w = 0; w < fr_d.size(); w++) begin
            ex.push_back(tx_model);
            dc_in = fr_dcq[w];
            for (int b = 7; b >= 0; b--) begin
                mosi_in = fr_d[w][b];
                repeat (half) tick();
                sclk_in = 1'b1;
                last_rise = cyc;
                rc.push_back(cyc);
                if (w == mid_load_word && b == 4) begin
                    tx_data_in = mid_load_val;
                    tx_load_in = 1'b1;
                    tx_model = mid_load_val;
                end
                if (b == 0) evq.push_back('{cyc + LAT, fr_d[w], fr_dcq[w], 1'b0});
                repeat (half) tick();
                sclk_in = 1'b0;
            end
        end
        for (int b = 0; b < partial_bits; b++) send_bit(1'($urandom_range(0, 1)));
        repeat (2) tick();
        cs_n_in = 1'b1;
        if (partial_bits > 0) evq.push_back('{cyc + LAT, 8'h00, 1'b0, 1'b1});
        repeat (8) tick();
        for (int w = 0; w < ex.size(); w++) begin
            for (int i = 0; i < 8; i++) got[7-i] = miso_log[(rc[w*8+i] + LAT) % 65536];
            check("miso_word", {24'd0, got}, {24'd0, ex[w]});
        end
        mosi_in = 1'b0;
        dc_in = 1'b0;
    endtask

    initial begin : main
        int ov0, fe0, nw;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_valid", {31'd0, rx_valid_out}, 32'd0);
        check("reset_data", {24'd0, rx_data_out}, 32'd0);
        check("reset_dc", {31'd0, rx_dc_out}, 32'd0);
        check("reset_ovr", {31'd0, rx_overrun_out}, 32'd0);
        check("reset_ferr", {31'd0, frame_error_out}, 32'd0);
        check("reset_miso", {31'd0, miso_out}, 32'd0);
        reset_in = 1'b0;
        chk_on = 1;
        tick();

        // Single word, fixed latency.
        rx_ready_in = 1'b1;
        half = 2;
        fr_d = '{8'hA5}; fr_dcq = '{1'b1}; partial_bits = 0;
        do_frame();
        check("t1_latency", valid_rise_cyc - last_rise, 32'd4);
        check("t1_data", {24'd0, rx_data_out}, 32'hA5);
        check("t1_dc", {31'd0, rx_dc_out}, 32'd1);
        check("t1_no_pulses", ovr_seen + ferr_seen, 32'd0);

        // Back-to-back words in one frame.
        fr_d = '{8'hAE, 8'h3C, 8'hFF}; fr_dcq = '{1'b0, 1'b1, 1'b1};
        do_frame();
        check("t2_last_data", {24'd0, rx_data_out}, 32'hFF);

        // Overrun while the consumer stalls.
        rx_ready_in = 1'b0;
        ov0 = ovr_seen;
        fr_d = '{8'h11, 8'h22}; fr_dcq = '{1'b1, 1'b0};
        do_frame();
        check("t3_held", {24'd0, rx_data_out}, 32'h11);
        check("t3_overrun_count", ovr_seen - ov0, 32'd1);
        rx_ready_in = 1'b1;
        tick();
        tick();
        check("t3_drained", {31'd0, rx_valid_out}, 32'd0);

        // MISO return path, including a mid-word holding-register update.
        load_tx(8'hC3);
        fr_d = '{8'h00, 8'h00}; fr_dcq = '{1'b1, 1'b1};
        do_frame();
        mid_load_word = 0; mid_load_val = 8'h5A;
        do_frame();
        mid_load_word = -1;

        // Aborted frame, then recovery.
        fe0 = ferr_seen;
        fr_d = {}; fr_dcq = {}; partial_bits = 5;
        do_frame();
        partial_bits = 0;
        check("t5_ferr_count", ferr_seen - fe0, 32'd1);
        fr_d = '{8'h81}; fr_dcq = '{1'b0};
        do_frame();
        check("t5_recover", {24'd0, rx_data_out}, 32'h81);

        // Reset during bit 3 with a word pending.
        rx_ready_in = 1'b0;
        fr_d = '{8'h77}; fr_dcq = '{1'b1};
        do_frame();
        cs_n_in = 1'b0;
        tick();
        tick();
        send_bit(1'b0);
        send_bit(1'b1);
        mosi_in = 1'b0;
        repeat (half) tick();
        sclk_in = 1'b1;
        #1;
        reset_in = 1'b1;
        #1;
        check("t6_valid", {31'd0, rx_valid_out}, 32'd0);
        check("t6_data", {24'd0, rx_data_out}, 32'd0);
        check("t6_dc", {31'd0, rx_dc_out}, 32'd0);
        check("t6_ovr", {31'd0, rx_overrun_out}, 32'd0);
        check("t6_ferr", {31'd0, frame_error_out}, 32'd0);
        check("t6_miso", {31'd0, miso_out}, 32'd0);
        sclk_in = 1'b0;
        cs_n_in = 1'b1;
        tx_model = 8'h00;
        repeat (3) tick();
        reset_in = 1'b0;
        tick();
        rx_ready_in = 1'b1;
        fr_d = '{8'h42}; fr_dcq = '{1'b1};
        do_frame();
        check("t6_recover", {24'd0, rx_data_out}, 32'h42);

        // Random frames with a randomly stalling consumer.
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            half = $urandom_range(2, 3);
            load_tx(8'($urandom));
            nw = $urandom_range(1, 4);
            fr_d = {}; fr_dcq = {};
            for (int w = 0; w < nw; w++) begin
                fr_d.push_back(8'($urandom));
                fr_dcq.push_back(1'($urandom_range(0, 1)));
            end
            partial_bits = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 0;
            do_frame();
        end
        rdy_mode = 0;
        partial_bits = 0;
        rx_ready_in = 1'b1;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
